// File: rtl/mem_bus_bridge_pkg.sv
// Shared definitions for the MEM-stage data bus bridge.
//   state_t       : bridge FSM encodings (S_IDLE/S_REQ/S_DONE)
//   size_t        : access size codes (byte/half/word)
//   mask_to_size  : store byte mask (lane-0 aligned) -> size code
//   misaligned    : alignment check for a size code and address low bits
package mem_bus_bridge_pkg;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_REQ  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  typedef enum logic [1:0] {
    SZ_BYTE = 2'd0,
    SZ_HALF = 2'd1,
    SZ_WORD = 2'd2
  } size_t;

  function automatic size_t mask_to_size(input logic [3:0] mask);
    if (mask == 4'b1111)      return SZ_WORD;
    else if (mask == 4'b0011) return SZ_HALF;
    else                      return SZ_BYTE;
  endfunction

  function automatic logic misaligned(input size_t sz, input logic [1:0] lo);
    case (sz)
      SZ_WORD: return lo != 2'b00;
      SZ_HALF: return lo[0];
      default: return 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/mem_bus_bridge_lane_align.sv
// Byte-lane steering between the CPU (lane-0 aligned data) and the word bus.
//   i_st_off  : store address low bits        o_st_data : store data shifted to lanes
//   i_st_data : store data, low lanes         o_st_be   : store strobes shifted to lanes
//   i_st_mask : store size mask, lane 0       o_ld_data : load data right-aligned
//   i_ld_off  : load address low bits
//   i_ld_data : raw bus read word
module mem_bus_bridge_lane_align (
  input  logic [1:0]  i_st_off,
  input  logic [31:0] i_st_data,
  input  logic [3:0]  i_st_mask,
  input  logic [1:0]  i_ld_off,
  input  logic [31:0] i_ld_data,
  output logic [31:0] o_st_data,
  output logic [3:0]  o_st_be,
  output logic [31:0] o_ld_data
);

  always_comb begin
    o_st_data = i_st_data << {i_st_off, 3'b000};
    o_st_be   = i_st_mask << i_st_off;
    o_ld_data = i_ld_data >> {i_ld_off, 3'b000};
  end

endmodule

// File: rtl/mem_bus_bridge.sv
// Data-side bridge between the CPU MEM stage and the request/ready memory bus.
// Registers one access, runs it on the bus, aligns data lanes, and stalls the
// pipeline until the access completes, is rejected as misaligned, or times out.
//   clk, reset                     : clock, synchronous active-high reset
//   cpu_rd/cpu_wr/cpu_addr         : MEM-stage access request
//   cpu_wdata/cpu_wmask/cpu_rsize  : store data + mask, load size
//   cpu_rdata/cpu_stall/cpu_err    : right-aligned load data, stall, error pulse
//   bus_req/bus_we/bus_addr/bus_be/bus_wdata : bus transaction outputs
//   bus_rdata/bus_ready            : bus read data and completion
module mem_bus_bridge
  import mem_bus_bridge_pkg::*;
#(
  parameter int unsigned TIMEOUT = 16,
  parameter int unsigned CNT_W   = 5
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        cpu_rd,
  input  logic        cpu_wr,
  input  logic [31:0] cpu_addr,
  input  logic [31:0] cpu_wdata,
  input  logic [3:0]  cpu_wmask,
  input  logic [1:0]  cpu_rsize,
  output logic [31:0] cpu_rdata,
  output logic        cpu_stall,
  output logic        cpu_err,
  output logic        bus_req,
  output logic        bus_we,
  output logic [31:0] bus_addr,
  output logic [3:0]  bus_be,
  output logic [31:0] bus_wdata,
  input  logic [31:0] bus_rdata,
  input  logic        bus_ready
);

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);

  state_t           r_state;
  logic [CNT_W-1:0] r_cnt;
  logic [31:0]      r_addr;
  logic [31:0]      r_wdata;
  logic [31:0]      r_rdata;
  logic [3:0]       r_be;
  logic             r_we;
  logic             r_req;
  logic             r_err;

  logic             w_access;
  size_t            w_size;
  logic             w_misal;
  logic [31:0]      w_st_data;
  logic [31:0]      w_ld_data;
  logic [3:0]       w_st_be;

  // A simultaneous rd+wr is treated as a store, so the store mask sets the size.
  always_comb begin
    w_access = cpu_rd | cpu_wr;
    w_size   = cpu_wr ? mask_to_size(cpu_wmask) : size_t'(cpu_rsize);
    w_misal  = misaligned(w_size, cpu_addr[1:0]);
  end

  // Store lanes come from the live CPU address; load lanes from the held one.
  mem_bus_bridge_lane_align u_align (
    .i_st_off  (cpu_addr[1:0]),
    .i_st_data (cpu_wdata),
    .i_st_mask (cpu_wmask),
    .i_ld_off  (r_addr[1:0]),
    .i_ld_data (bus_rdata),
    .o_st_data (w_st_data),
    .o_st_be   (w_st_be),
    .o_ld_data (w_ld_data)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= S_IDLE;
      r_cnt   <= '0;
      r_addr  <= '0;
      r_wdata <= '0;
      r_rdata <= '0;
      r_be    <= '0;
      r_we    <= 1'b0;
      r_req   <= 1'b0;
      r_err   <= 1'b0;
    end else begin
      r_err <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (w_access) begin
            r_addr  <= cpu_addr;
            r_we    <= cpu_wr;
            r_wdata <= cpu_wr ? w_st_data : '0;
            r_be    <= cpu_wr ? w_st_be : '0;
            r_cnt   <= '0;
            if (w_misal) begin
              r_state <= S_DONE;
              r_err   <= 1'b1;
              r_rdata <= '0;
            end else begin
              r_state <= S_REQ;
              r_req   <= 1'b1;
            end
          end
        end
        S_REQ: begin
          // Ready is tested first so it wins over a coincident timeout.
          if (bus_ready) begin
            r_rdata <= w_ld_data;
            r_req   <= 1'b0;
            r_state <= S_DONE;
          end else if (r_cnt == CNT_LAST) begin
            r_rdata <= '0;
            r_err   <= 1'b1;
            r_req   <= 1'b0;
            r_state <= S_DONE;
          end else begin
            r_cnt <= r_cnt + CNT_W'(1);
          end
        end
        S_DONE:  r_state <= S_IDLE;
        default: r_state <= S_IDLE;
      endcase
    end
  end

  always_comb begin
    cpu_stall = ((r_state == S_IDLE) && w_access) || (r_state == S_REQ);
    cpu_rdata = r_rdata;
    cpu_err   = r_err;
    bus_req   = r_req;
    bus_we    = r_we;
    bus_addr  = {r_addr[31:2], 2'b00};
    bus_be    = r_be;
    bus_wdata = r_wdata;
  end

endmodule

// File: tb/tb_mem_bus_bridge.sv
module tb_mem_bus_bridge;

  logic        clk = 1'b0;
  logic        reset;
  logic        cpu_rd, cpu_wr;
  logic [31:0] cpu_addr, cpu_wdata;
  logic [3:0]  cpu_wmask;
  logic [1:0]  cpu_rsize;
  logic [31:0] cpu_rdata;
  logic        cpu_stall, cpu_err;
  logic        bus_req, bus_we;
  logic [31:0] bus_addr, bus_wdata, bus_rdata;
  logic [3:0]  bus_be;
  logic        bus_ready;

  always #5 clk = ~clk;

  mem_bus_bridge #(.TIMEOUT(16), .CNT_W(5)) dut (
    .clk(clk), .reset(reset),
    .cpu_rd(cpu_rd), .cpu_wr(cpu_wr), .cpu_addr(cpu_addr),
    .cpu_wdata(cpu_wdata), .cpu_wmask(cpu_wmask), .cpu_rsize(cpu_rsize),
    .cpu_rdata(cpu_rdata), .cpu_stall(cpu_stall), .cpu_err(cpu_err),
    .bus_req(bus_req), .bus_we(bus_we), .bus_addr(bus_addr),
    .bus_be(bus_be), .bus_wdata(bus_wdata),
    .bus_rdata(bus_rdata), .bus_ready(bus_ready)
  );

  int total = 0;
  int bad   = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", nm, act, exp);
    end
  endtask

  task automatic chk_all_zero(input string p);
    chk({p, "_stall"}, 32'(cpu_stall), 32'd0);
    chk({p, "_err"},   32'(cpu_err),   32'd0);
    chk({p, "_rdata"}, cpu_rdata,      32'd0);
    chk({p, "_req"},   32'(bus_req),   32'd0);
    chk({p, "_we"},    32'(bus_we),    32'd0);
    chk({p, "_addr"},  bus_addr,       32'd0);
    chk({p, "_be"},    32'(bus_be),    32'd0);
    chk({p, "_wdata"}, bus_wdata,      32'd0);
  endtask

  typedef struct {
    string       name;
    logic        rd;
    logic        wr;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [3:0]  wmask;
    logic [1:0]  rsize;
    logic [31:0] brdata;
    int          ready_at;   // REQ cycle (1-based) that sees bus_ready; 0 = never
    int          e_stall;
    int          e_req;
    logic        e_err;
    logic [31:0] e_rdata;
    logic [31:0] e_addr;
    logic [3:0]  e_be;
    logic        e_we;
    logic [31:0] e_wdata;
  } vec_t;

  task automatic run_vec(input vec_t v);
    int          stall_n = 0;
    int          req_n   = 0;
    logic        done    = 1'b0;
    logic        got_err = 1'b0;
    logic        f_we    = 1'b0;
    logic [3:0]  f_be    = '0;
    logic [31:0] got_rdata = '0;
    logic [31:0] f_addr    = '0;
    logic [31:0] f_wdata   = '0;
    @(negedge clk);
    cpu_rd = v.rd; cpu_wr = v.wr; cpu_addr = v.addr; cpu_wdata = v.wdata;
    cpu_wmask = v.wmask; cpu_rsize = v.rsize; bus_rdata = v.brdata; bus_ready = 1'b0;
    for (int c = 0; c < 64 && !done; c++) begin
      #1;
      if (cpu_stall) begin
        stall_n++;
        if (bus_req) begin
          req_n++;
          if (req_n == 1) begin
            f_addr = bus_addr; f_be = bus_be; f_we = bus_we; f_wdata = bus_wdata;
          end
        end
        bus_ready = bus_req && (v.ready_at != 0) && (req_n == v.ready_at);
        @(negedge clk);
      end else begin
        done = 1'b1;
        got_err = cpu_err;
        got_rdata = cpu_rdata;
        chk({v.name, "_req_done"}, 32'(bus_req), 32'd0);
        cpu_rd = 1'b0; cpu_wr = 1'b0; bus_ready = 1'b0;
      end
    end
    chk({v.name, "_done"}, 32'(done), 32'd1);
    if (!done) begin
      cpu_rd = 1'b0; cpu_wr = 1'b0; bus_ready = 1'b0;
    end
    chk({v.name, "_stall_cycles"}, 32'(stall_n), 32'(v.e_stall));
    chk({v.name, "_req_cycles"},   32'(req_n),   32'(v.e_req));
    chk({v.name, "_err"},          32'(got_err), 32'(v.e_err));
    chk({v.name, "_rdata"},        got_rdata,    v.e_rdata);
    if (v.e_req > 0) begin
      chk({v.name, "_bus_addr"}, f_addr,      v.e_addr);
      chk({v.name, "_bus_be"},   32'(f_be),   32'(v.e_be));
      chk({v.name, "_bus_we"},   32'(f_we),   32'(v.e_we));
      if (v.e_we) chk({v.name, "_bus_wdata"}, f_wdata, v.e_wdata);
    end
    @(negedge clk);
    #1;
    chk({v.name, "_err_cleared"}, 32'(cpu_err), 32'd0);
    chk({v.name, "_idle_stall"},  32'(cpu_stall), 32'd0);
  endtask

  localparam int NV = 11;
  vec_t vecs [NV];

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [5:0] exp_st;
    logic [5:0] exp_rq;
    vec_t       v_after;

    //           name  rd   wr   addr          wdata          mask   rsz   brdata        rdy st  rq err   rdata          bus_addr      be     we    bus_wdata
    vecs[0]  = '{"sw",  1'b0,1'b1,32'h0000_0104,32'hA5A5_1234,4'hF,2'd2,32'h0000_0000,1,  2,  1, 1'b0,32'h0000_0000,32'h0000_0104,4'hF,1'b1,32'hA5A5_1234};
    vecs[1]  = '{"sb",  1'b0,1'b1,32'h0000_0107,32'h0000_00EE,4'h1,2'd0,32'h0000_0000,1,  2,  1, 1'b0,32'h0000_0000,32'h0000_0104,4'h8,1'b1,32'hEE00_0000};
    vecs[2]  = '{"lh",  1'b1,1'b0,32'h0000_0202,32'h0,        4'h0,2'd1,32'hBEEF_0000,4,  5,  4, 1'b0,32'h0000_BEEF,32'h0000_0200,4'h0,1'b0,32'h0};
    vecs[3]  = '{"lw_mis",1'b1,1'b0,32'h0000_0301,32'h0,      4'h0,2'd2,32'hFFFF_FFFF,1,  1,  0, 1'b1,32'h0000_0000,32'h0,        4'h0,1'b0,32'h0};
    vecs[4]  = '{"lb",  1'b1,1'b0,32'h0000_0503,32'h0,        4'h0,2'd0,32'h7F00_0000,2,  3,  2, 1'b0,32'h0000_007F,32'h0000_0500,4'h0,1'b0,32'h0};
    vecs[5]  = '{"lw_to",1'b1,1'b0,32'h0000_0400,32'h0,       4'h0,2'd2,32'hDEAD_BEEF,0,  17, 16,1'b1,32'h0000_0000,32'h0000_0400,4'h0,1'b0,32'h0};
    vecs[6]  = '{"lw_r16",1'b1,1'b0,32'h0000_0400,32'h0,      4'h0,2'd2,32'h1234_5678,16, 17, 16,1'b0,32'h1234_5678,32'h0000_0400,4'h0,1'b0,32'h0};
    vecs[7]  = '{"rdwr_sh",1'b1,1'b1,32'h0000_0012,32'h0000_CAFE,4'h3,2'd2,32'h0,        1,  2,  1, 1'b0,32'h0000_0000,32'h0000_0010,4'hC,1'b1,32'hCAFE_0000};
    vecs[8]  = '{"sh_mis",1'b0,1'b1,32'h0000_0101,32'h0000_1111,4'h3,2'd0,32'h0,         1,  1,  0, 1'b1,32'h0000_0000,32'h0,        4'h0,1'b0,32'h0};
    vecs[9]  = '{"lh_hi",1'b1,1'b0,32'h0000_0006,32'h0,       4'h0,2'd1,32'h1234_5678,3,  4,  3, 1'b0,32'h0000_1234,32'h0000_0004,4'h0,1'b0,32'h0};
    vecs[10] = '{"sb0", 1'b0,1'b1,32'h0000_0000,32'h1122_3344,4'h1,2'd0,32'h0,           1,  2,  1, 1'b0,32'h0000_0000,32'h0000_0000,4'h1,1'b1,32'h1122_3344};

    reset = 1'b1; cpu_rd = 1'b0; cpu_wr = 1'b0; cpu_addr = '0; cpu_wdata = '0;
    cpu_wmask = '0; cpu_rsize = '0; bus_rdata = '0; bus_ready = 1'b0;
    repeat (2) @(negedge clk);
    #1;
    chk_all_zero("reset");
    reset = 1'b0;

    for (int i = 0; i < NV; i++) run_vec(vecs[i]);

    // Back-to-back loads with bus_ready held high everywhere: ready outside
    // S_REQ must be ignored and the held request re-accepted only after S_DONE.
    exp_st = 6'b011011;
    exp_rq = 6'b010010;
    @(negedge clk);
    cpu_rd = 1'b1; cpu_wr = 1'b0; cpu_addr = 32'h0000_0700; cpu_rsize = 2'd2;
    bus_rdata = 32'hA1B2_C3D4; bus_ready = 1'b1;
    for (int k = 0; k < 6; k++) begin
      #1;
      chk($sformatf("b2b_stall_c%0d", k), 32'(cpu_stall), 32'(exp_st[k]));
      chk($sformatf("b2b_req_c%0d", k),   32'(bus_req),   32'(exp_rq[k]));
      chk($sformatf("b2b_err_c%0d", k),   32'(cpu_err),   32'd0);
      if (k == 2) chk("b2b_rdata", cpu_rdata, 32'hA1B2_C3D4);
      if (k == 5) cpu_rd = 1'b0;
      @(negedge clk);
    end
    bus_ready = 1'b0;

    // Reset in the second REQ cycle abandons the access silently.
    cpu_rd = 1'b1; cpu_addr = 32'h0000_0600; cpu_rsize = 2'd2; bus_rdata = 32'h5555_AAAA;
    #1;
    chk("rst_idle_stall", 32'(cpu_stall), 32'd1);
    @(negedge clk); #1;
    chk("rst_req1", 32'(bus_req), 32'd1);
    @(negedge clk); #1;
    chk("rst_req2", 32'(bus_req), 32'd1);
    reset = 1'b1; cpu_rd = 1'b0;
    @(negedge clk); #1;
    chk_all_zero("rst_mid");
    reset = 1'b0;
    v_after = '{"lw_post_rst",1'b1,1'b0,32'h0000_0604,32'h0,4'h0,2'd2,32'h0BAD_F00D,1,2,1,1'b0,
                32'h0BAD_F00D,32'h0000_0604,4'h0,1'b0,32'h0};
    run_vec(v_after);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
